inst_queue_dispatcher: RTL and testbench

Consumer end of the instruction FIFO. Pops decoded-instruction words from the FIFO's read/empty/data interface into a 2-entry output buffer and presents them to the reservation-station dispatch port with a valid/ready handshake. The buffer registers the output, so downstream ready never reaches the FIFO read strobe combinationally. Supports pipeline flush on branch mispredict and tags each dispatched word with a wrapping sequence number.

---
 rtl/inst_queue_dispatcher_if.sv | 37 +++
 rtl/inst_queue_dispatcher.sv | 120 ++++++++++++
 tb/tb_inst_queue_dispatcher.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_dispatcher_if.sv
// Dispatcher-side bundle: FIFO read port, flush, and reservation-station dispatch port.
// The DUT uses the slave modport; the environment (FIFO + reservation stations) uses master.
interface inst_queue_dispatcher_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_WIDTH  = 4
);
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  flush;
    logic                  dispatch_valid;
    logic                  dispatch_ready;
    logic [DATA_WIDTH-1:0] dispatch_data;
    logic [SEQ_WIDTH-1:0]  dispatch_seq;

    modport slave (
        output fifo_read,
        input  fifo_data,
        input  fifo_empty,
        input  flush,
        output dispatch_valid,
        input  dispatch_ready,
        output dispatch_data,
        output dispatch_seq
    );

    modport master (
        input  fifo_read,
        output fifo_data,
        output fifo_empty,
        output flush,
        input  dispatch_valid,
        output dispatch_ready,
        input  dispatch_data,
        input  dispatch_seq
    );
endinterface

// File: rtl/inst_queue_dispatcher.sv
// Instruction-FIFO consumer: 2-entry head/skid buffer feeding the dispatch port with seq tags.
// Optional macro DISPATCH_NOP_DROP_EN pops canonical NOPs (32'h00000013) without buffering them.
module inst_queue_dispatcher #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    inst_queue_dispatcher_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e                state_q,     state_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEQ_WIDTH-1:0]  head_seq_q,  head_seq_d;
    logic [SEQ_WIDTH-1:0]  skid_seq_q,  skid_seq_d;
    logic [SEQ_WIDTH-1:0]  next_seq_q,  next_seq_d;

    logic fifo_read;
    logic dispatch_valid;
    logic push;
    logic pop;
    logic is_nop;

`ifdef DISPATCH_NOP_DROP_EN
    localparam bit                    NopDropActive = (DATA_WIDTH == 32);
    localparam logic [DATA_WIDTH-1:0] NopWord       = DATA_WIDTH'(32'h0000_0013);

    assign is_nop = NopDropActive && (bus.fifo_data == NopWord);
`else
    assign is_nop = 1'b0;
`endif

    // Read strobe depends only on registered occupancy, empty and flush, never on dispatch_ready.
    assign fifo_read      = !bus.fifo_empty && !bus.flush && (state_q != ST_TWO);
    assign dispatch_valid = (state_q != ST_EMPTY) && !bus.flush;
    assign pop            = dispatch_valid && bus.dispatch_ready;
    assign push           = fifo_read && !is_nop;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path through this block can infer a latch.
        state_d     = state_q;
        head_data_d = head_data_q;
        skid_data_d = skid_data_q;
        head_seq_d  = head_seq_q;
        skid_seq_d  = skid_seq_q;
        next_seq_d  = next_seq_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_data_d = bus.fifo_data;
                    head_seq_d  = next_seq_q;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_data_d = bus.fifo_data;
                    head_seq_d  = next_seq_q;
                end else if (push) begin
                    skid_data_d = bus.fifo_data;
                    skid_seq_d  = next_seq_q;
                    state_d     = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    head_data_d = skid_data_q;
                    head_seq_d  = skid_seq_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (push) begin
            next_seq_d = next_seq_q + SEQ_WIDTH'(1);
        end

        // Flush empties the buffer but keeps the tag counter running across mispredicts.
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            // NOTE: buffer contents are reset too, so dispatch_data/seq read 0 until the first word arrives.
            head_data_q <= '0;
            skid_data_q <= '0;
            head_seq_q  <= '0;
            skid_seq_q  <= '0;
            next_seq_q  <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            skid_data_q <= skid_data_d;
            head_seq_q  <= head_seq_d;
            skid_seq_q  <= skid_seq_d;
            next_seq_q  <= next_seq_d;
        end
    end

    assign bus.fifo_read      = fifo_read;
    assign bus.dispatch_valid = dispatch_valid;
    assign bus.dispatch_data  = head_data_q;
    assign bus.dispatch_seq   = head_seq_q;

endmodule

// File: tb/tb_inst_queue_dispatcher.sv
// Scoreboard bench for inst_queue_dispatcher: a queue-based reference of the 2-deep buffer,
// a FIFO model driven by fifo_read, and a negedge monitor comparing every dispatch.
module tb_inst_queue_dispatcher;

    localparam int DW = 32;
    localparam int SW = 4;

`ifdef DISPATCH_NOP_DROP_EN
    localparam bit NopDrop = 1'b1;
`else
    localparam bit NopDrop = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] seq;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_queue_dispatcher_if #(.DATA_WIDTH(DW), .SEQ_WIDTH(SW)) bus ();
    inst_queue_dispatcher    #(.DATA_WIDTH(DW), .SEQ_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    entry_t        exp_q[$];
    logic [DW-1:0] env_q[$];
    int            next_seq      = 0;
    int            occ_at_check  = 0;
    int            tests_run     = 0;
    int            tests_failed  = 0;
    int            ready_pct     = 100;
    int            flush_pct     = 0;
    int            stall_pct     = 0;
    bit            force_flush   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_nop(input logic [DW-1:0] w);
        return NopDrop && (w == 32'h0000_0013);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = (($urandom_range(7) == 0) ? 32'h0000_0013 : $urandom);
        return w;
    endfunction

    // Environment driver: FIFO head from env_q, random stalls/flushes, random ready.
    initial begin
        bus.fifo_empty     = 1'b1;
        bus.fifo_data      = '0;
        bus.flush          = 1'b0;
        bus.dispatch_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.fifo_empty = 1'b1;
                bus.fifo_data  = $urandom;
                bus.flush      = 1'b0;
            end else begin
                bus.fifo_empty = (env_q.size() == 0) || (int'($urandom_range(99)) < stall_pct);
                bus.fifo_data  = bus.fifo_empty ? DW'($urandom) : env_q[0];
                bus.flush      = force_flush || (int'($urandom_range(99)) < flush_pct);
            end
            bus.dispatch_ready = (int'($urandom_range(99)) < ready_pct);
        end
    end

    // Monitor: compares the visible outputs and retires the head on a handshake.
    always begin
        @(negedge clk);
        occ_at_check = exp_q.size();
        if (!rst) begin
            check("fifo_read", 64'(bus.fifo_read),
                  64'(!bus.fifo_empty && !bus.flush && (exp_q.size() < 2)));
            check("dispatch_valid", 64'(bus.dispatch_valid),
                  64'((exp_q.size() != 0) && !bus.flush));
            if (bus.dispatch_valid && exp_q.size() != 0) begin
                check("dispatch_data", 64'(bus.dispatch_data), 64'(exp_q[0].data));
                check("dispatch_seq",  64'(bus.dispatch_seq),  64'(exp_q[0].seq));
            end
            if (!bus.flush && exp_q.size() != 0 && bus.dispatch_ready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // Reference model: words enter the expected queue when the buffer has room; flush/reset clear it.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            next_seq = 0;
        end else if (bus.flush) begin
            exp_q.delete();
        end else if (!bus.fifo_empty && occ_at_check < 2) begin
            if (!is_nop(bus.fifo_data)) begin
                entry_t e;
                e.data = bus.fifo_data;
                e.seq  = SW'(next_seq);
                exp_q.push_back(e);
                next_seq = (next_seq + 1) % (1 << SW);
            end
        end
        if (bus.fifo_read && !bus.fifo_empty && env_q.size() != 0) begin
            void'(env_q.pop_front());
        end
    end

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2;
        rst = 1'b1;
        env_q.delete();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("reset_fifo_read",      64'(bus.fifo_read),      64'(0));
        check("reset_dispatch_valid", 64'(bus.dispatch_valid), 64'(0));
        check("reset_dispatch_data",  64'(bus.dispatch_data),  64'(0));
        check("reset_dispatch_seq",   64'(bus.dispatch_seq),   64'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((env_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_timeout", 64'(n < budget), 64'(1));
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    initial begin
        do_reset(2);

        // Three words with ready held high: back-to-back dispatch, seq 0,1,2.
        ready_pct = 100; flush_pct = 0; stall_pct = 0;
        env_q.push_back(32'hA000_0001);
        env_q.push_back(32'hA000_0002);
        env_q.push_back(32'hA000_0003);
        drain(50);

        // Backpressure: buffer fills to two and stops reading, then drains in order.
        ready_pct = 0;
        for (int i = 0; i < 5; i++) env_q.push_back(32'hB000_0000 + 32'(i));
        settle(6);
        ready_pct = 100;
        drain(50);

        // Flush while full with FIFO still non-empty; tags keep counting afterwards.
        ready_pct = 0;
        for (int i = 0; i < 4; i++) env_q.push_back(32'hC000_0000 + 32'(i));
        settle(4);
        force_flush = 1'b1;
        settle(1);
        force_flush = 1'b0;
        ready_pct   = 100;
        drain(50);

        // Seventeen words walk the tag through its wrap.
        for (int i = 0; i < 17; i++) env_q.push_back(32'hD000_0000 + 32'(i));
        drain(100);

        // NOP handling (dropped only when the option is compiled in).
        env_q.push_back(32'h0000_0013);
        env_q.push_back(32'h0000_00AA);
        env_q.push_back(32'h0000_0013);
        env_q.push_back(32'h0000_00BB);
        drain(50);

        // Randomized traffic with stalls, backpressure, flushes and one mid-run reset.
        for (int b = 0; b < 4; b++) begin
            ready_pct = int'($urandom_range(30, 100));
            flush_pct = int'($urandom_range(0, 8));
            stall_pct = int'($urandom_range(0, 40));
            for (int i = 0; i < 40; i++) env_q.push_back(rand_word());
            settle(30);
            if (b == 2) begin
                rst = 1'b1;
                settle(2);
                rst = 1'b0;
            end
            drain(2000);
        end

        settle(3);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
